// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared sizing and requester constants for the register-file writeback arbiter.
// Imported by the interface, the top and the testbench.
package regfile_writeback_arbiter_pkg;

  localparam int NUM_REQ  = 3;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int IDX_W    = $clog2(NUM_REQ);

  localparam int REQ_ALU  = 0;
  localparam int REQ_MEM  = 1;
  localparam int REQ_LINK = 2;

  // Round-robin successor of a requester index, wrapping at NUM_REQ.
  function automatic logic [IDX_W-1:0] wrap_next(input logic [IDX_W-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/regfile_writeback_arbiter_if.sv
// Bundles the writeback requests, reserve/query scoreboard port and register-file write port.
// The master side is the pipeline; the slave side is the arbiter.
interface regfile_writeback_arbiter_if;
  import regfile_writeback_arbiter_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_address;
  logic [NUM_REQ*DATA_W-1:0] req_value;
  logic [NUM_REQ-1:0]        req_ready;

  logic                      reserve_valid;
  logic [ADDR_W-1:0]         reserve_address;
  logic                      reserve_ready;
  logic                      flush;

  logic [ADDR_W-1:0]         query_a_address;
  logic [ADDR_W-1:0]         query_b_address;
  logic                      busy_a;
  logic                      busy_b;
  logic [NUM_REGS-1:0]       busy_mask;

  logic                      reg_write;
  logic [ADDR_W-1:0]         reg_write_address;
  logic [DATA_W-1:0]         reg_write_value;

  modport master (
    output req_valid, req_address, req_value, reserve_valid, reserve_address,
           flush, query_a_address, query_b_address,
    input  req_ready, reserve_ready, busy_a, busy_b, busy_mask,
           reg_write, reg_write_address, reg_write_value
  );

  modport slave (
    input  req_valid, req_address, req_value, reserve_valid, reserve_address,
           flush, query_a_address, query_b_address,
    output req_ready, reserve_ready, busy_a, busy_b, busy_mask,
           reg_write, reg_write_address, reg_write_value
  );

endinterface

// File: rtl/regfile_writeback_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter: scans upward from ptr (mod NUM_REQ)
// and grants the first valid requester, producing a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && valid[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        grant_any   = 1'b1;
      end
      cand = (int'(cand) == NUM_REQ - 1) ? '0 : cand + IDX_W'(1);
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Shares the single register-file write port among the writeback sources and keeps
// the per-register busy scoreboard that decode uses for RAW/WAW stalls.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
(
  input logic clk,
  input logic rst,
  regfile_writeback_arbiter_if.slave bus
);

  logic [IDX_W-1:0]    ptr;
  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_any;
  logic [ADDR_W-1:0]   grant_address;
  logic [DATA_W-1:0]   grant_value;

  logic [NUM_REGS-1:0] busy_mask;
  logic [NUM_REGS-1:0] busy_next;
  logic                clear_hit;
  logic                reserve_ok;

  logic                write_q;
  logic [ADDR_W-1:0]   write_address_q;
  logic [DATA_W-1:0]   write_value_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .valid     (bus.req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign grant_address = bus.req_address[grant_idx*ADDR_W +: ADDR_W];
  assign grant_value   = bus.req_value[grant_idx*DATA_W +: DATA_W];

  // A register whose pending write lands this cycle may be re-claimed in the same cycle.
  assign clear_hit  = grant_any && (grant_address == bus.reserve_address);
  assign reserve_ok = bus.reserve_valid && !bus.flush &&
                      (!busy_mask[bus.reserve_address] || clear_hit);

  // Reserve is applied after the clear so a same-cycle re-claim leaves the register busy.
  always_comb begin
    busy_next = busy_mask;
    if (bus.flush) begin
      busy_next = '0;
    end else begin
      if (grant_any) busy_next[grant_address] = 1'b0;
      if (reserve_ok) busy_next[bus.reserve_address] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr             <= '0;
      busy_mask       <= '0;
      write_q         <= 1'b0;
      write_address_q <= '0;
      write_value_q   <= '0;
    end else begin
      busy_mask <= busy_next;
      write_q   <= grant_any;
      if (grant_any) begin
        ptr             <= wrap_next(grant_idx);
        write_address_q <= grant_address;
        write_value_q   <= grant_value;
      end
    end
  end

  assign bus.req_ready         = grant;
  assign bus.reserve_ready     = reserve_ok;
  assign bus.busy_mask         = busy_mask;
  assign bus.busy_a            = busy_mask[bus.query_a_address];
  assign bus.busy_b            = busy_mask[bus.query_b_address];
  assign bus.reg_write         = write_q;
  assign bus.reg_write_address = write_address_q;
  assign bus.reg_write_value   = write_value_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Table-driven bench for the writeback arbiter; accepted transfers are queued as
// expected register-file writes and popped when the write port fires.
module tb_regfile_writeback_arbiter;
  import regfile_writeback_arbiter_pkg::*;

  typedef struct {
    logic [2:0]  valid;
    logic [8:0]  addr;
    logic [47:0] val;
    logic        rsv;
    logic [2:0]  rsv_addr;
    logic        flush;
    logic [2:0]  qa;
    logic [2:0]  qb;
    logic [2:0]  exp_ready;
    logic        exp_rsv_ready;
    logic        exp_busy_a;
    logic        exp_busy_b;
    logic [7:0]  exp_mask;
  } vec_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] value;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   compared = 0;
  int   mismatched = 0;
  wr_t  sb[$];
  vec_t vecs[$];

  regfile_writeback_arbiter_if bus ();

  regfile_writeback_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [2:0] a0, a1, a2,
    input logic [15:0] v0, v1, v2,
    input logic rsv, input logic [2:0] rsv_addr, input logic flush,
    input logic [2:0] qa, qb, input logic [2:0] exp_ready, input logic exp_rr,
    input logic exp_ba, exp_bb, input logic [7:0] exp_mask);
    vec_t v;
    v.valid = valid;         v.addr = {a2, a1, a0};   v.val = {v2, v1, v0};
    v.rsv = rsv;             v.rsv_addr = rsv_addr;   v.flush = flush;
    v.qa = qa;               v.qb = qb;               v.exp_ready = exp_ready;
    v.exp_rsv_ready = exp_rr; v.exp_busy_a = exp_ba;  v.exp_busy_b = exp_bb;
    v.exp_mask = exp_mask;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    bus.req_valid       = v.valid;
    bus.req_address     = v.addr;
    bus.req_value       = v.val;
    bus.reserve_valid   = v.rsv;
    bus.reserve_address = v.rsv_addr;
    bus.flush           = v.flush;
    bus.query_a_address = v.qa;
    bus.query_b_address = v.qb;
  endtask

  // Called #1 after a rising edge: a write is due exactly when the previous cycle granted.
  task automatic checkOutput(input logic [7:0] exp_mask, input string name);
    wr_t w;
    cmp({name, " busy_mask"}, bus.busy_mask, exp_mask);
    cmp({name, " reg_write"}, bus.reg_write, sb.size() > 0);
    if (sb.size() > 0) begin
      w = sb.pop_front();
      cmp({name, " wr_addr"}, bus.reg_write_address, w.addr);
      cmp({name, " wr_value"}, bus.reg_write_value, w.value);
    end
  endtask

  task automatic runVector(input vec_t v, input string name);
    wr_t w;
    applyStimulus(v);
    #2;
    cmp({name, " ready"}, bus.req_ready, v.exp_ready);
    cmp({name, " reserve_ready"}, bus.reserve_ready, v.exp_rsv_ready);
    cmp({name, " busy_a"}, bus.busy_a, v.exp_busy_a);
    cmp({name, " busy_b"}, bus.busy_b, v.exp_busy_b);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v.exp_ready[i]) begin
        w.addr  = v.addr[i*ADDR_W +: ADDR_W];
        w.value = v.val[i*DATA_W +: DATA_W];
        sb.push_back(w);
      end
    end
    @(posedge clk);
    #1;
    checkOutput(v.exp_mask, name);
  endtask

  initial begin
    vec_t idle;
    idle = mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 8'h00);

    // valid  a0 a1 a2  v0 v1 v2  rsv raddr flush  qa qb  ready rr ba bb  mask
    vecs.push_back(mk(3'b111, 1, 5, 6, 16'h1111, 16'hBEEF, 16'h2222, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 8'h00));
    vecs.push_back(mk(3'b111, 1, 5, 6, 16'h1111, 16'hBEEF, 16'h2222, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 8'h00));
    vecs.push_back(mk(3'b111, 1, 5, 6, 16'h1111, 16'hBEEF, 16'h2222, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0, 8'h00));
    vecs.push_back(mk(3'b111, 1, 5, 6, 16'h1111, 16'hBEEF, 16'h2222, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 8'h00));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 0, 3'b000, 1, 0, 0, 8'h08));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 2, 3'b000, 0, 1, 0, 8'h08));
    vecs.push_back(mk(3'b001, 3, 0, 0, 16'h1234, 0, 0, 0, 0, 0, 3, 0, 3'b001, 0, 1, 0, 8'h00));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 3'b000, 0, 0, 0, 8'h00));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 2, 0, 2, 3, 3'b000, 1, 0, 0, 8'h04));
    vecs.push_back(mk(3'b010, 0, 2, 0, 0, 16'hABCD, 0, 1, 2, 0, 2, 0, 3'b010, 1, 1, 0, 8'h04));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 3'b000, 0, 1, 0, 8'h04));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 1, 3'b000, 1, 1, 0, 8'h06));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 4, 3'b000, 1, 1, 0, 8'h16));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 6, 0, 4, 6, 3'b000, 1, 1, 0, 8'h56));
    vecs.push_back(mk(3'b100, 0, 0, 7, 0, 0, 16'h7777, 1, 5, 1, 6, 5, 3'b100, 0, 1, 0, 8'h00));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 7, 3'b000, 0, 0, 0, 8'h00));
    vecs.push_back(mk(3'b110, 0, 0, 3, 0, 16'h0F0F, 16'h5555, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 8'h00));
    vecs.push_back(mk(3'b011, 7, 1, 0, 16'hFFFF, 16'hAAAA, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 8'h00));
    vecs.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 0, 3'b000, 1, 0, 0, 8'h20));

    applyStimulus(idle);
    repeat (2) @(posedge clk);
    #1;
    cmp("reset reg_write", bus.reg_write, 1'b0);
    cmp("reset busy_mask", bus.busy_mask, 8'h00);
    cmp("reset ready", bus.req_ready, 3'b000);
    cmp("reset wr_addr", bus.reg_write_address, 3'd0);
    cmp("reset wr_value", bus.reg_write_value, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Reset lands on the edge that would register a grant: the write must be dropped.
    applyStimulus(mk(3'b001, 4, 0, 0, 16'h4444, 0, 0, 1, 6, 0, 0, 0, 3'b001, 1, 0, 0, 8'h00));
    #2;
    cmp("rstmid ready", bus.req_ready, 3'b001);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cmp("rstmid reg_write", bus.reg_write, 1'b0);
    cmp("rstmid busy_mask", bus.busy_mask, 8'h00);
    cmp("rstmid wr_addr", bus.reg_write_address, 3'd0);
    rst = 1'b0;
    runVector(mk(3'b111, 2, 3, 4, 16'h0001, 16'h0002, 16'h0003, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 8'h00),
              "post_rst ptr");
    runVector(idle, "drain");
    cmp("scoreboard empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
